jtkcpu_simctl: RTL

Synthesisable, parametrised simulation-control peripheral for CPU test benches. It sits on the CPU data bus as a four-register device and does three things: it latches a pass/fail flag, runs a finish countdown, and drives up to CHN active-low interrupt lines. Interrupt assertion is delayed by a programmable or LFSR-random number of bus cycles. It replaces ad-hoc bench logic, so the same control block can run in simulation and on FPGA.

---
 rtl/jtkcpu_simctl_if.sv | 26 ++
 rtl/jtkcpu_simctl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/jtkcpu_simctl_if.sv
// Bus bundle for the simulation-control peripheral: CPU-side strobes and data,
// plus the interrupt and finish status lines it drives back.
interface jtkcpu_simctl_if #(
  parameter int unsigned CHN = 3
) ();
  logic           cen;
  logic           cs;
  logic           we;
  logic [1:0]     addr;
  logic [7:0]     din;
  logic [7:0]     dout;
  logic [CHN-1:0] irq_n;
  logic           done;
  logic           pass;
  logic           fail;

  modport master (
    output cen, cs, we, addr, din,
    input  dout, irq_n, done, pass, fail
  );

  modport slave (
    input  cen, cs, we, addr, din,
    output dout, irq_n, done, pass, fail
  );
endinterface

// File: rtl/jtkcpu_simctl.sv
// Simulation-control peripheral: pass/fail latch, finish countdown and
// delayed active-low interrupt lines, mapped as four byte registers.
module jtkcpu_simctl #(
  parameter int unsigned CHN        = 3,
  parameter int unsigned DLYW       = 7,
  parameter int unsigned FINISH_DLY = 20,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input logic           clk,
  input logic           rst_n,
  jtkcpu_simctl_if.slave bus
);

  localparam int unsigned FW = (FINISH_DLY < 1) ? 1 : $clog2(FINISH_DLY + 1);

  logic [15:0]     r_lfsr;
  logic [CHN-1:0]  r_req;
  logic [CHN-1:0]  r_act;
  logic [CHN-1:0]  r_irq_n;
  logic [DLYW-1:0] r_dly;
  logic [DLYW-1:0] r_cnt;
  logic            r_mode;
  logic            r_armed;
  logic            r_good;
  logic            r_done;
  logic            r_fin_run;
  logic [FW-1:0]   r_fin_cnt;

  logic            w_wr;
  logic            w_wr_ctrl;
  logic            w_wr_req;
  logic            w_wr_dly;
  logic            w_wr_ack;
  logic            w_fire;
  logic [CHN-1:0]  w_req_d;
  logic [CHN-1:0]  w_act_d;
  logic [7:0]      w_rd;

  assign w_wr      = bus.cs & bus.we & bus.cen;
  assign w_wr_ctrl = w_wr & (bus.addr == 2'd0);
  assign w_wr_req  = w_wr & (bus.addr == 2'd1);
  assign w_wr_dly  = w_wr & (bus.addr == 2'd2);
  assign w_wr_ack  = w_wr & (bus.addr == 2'd3);

  // A REQ write on the same cen reloads the counter, so it suppresses the fire.
  assign w_fire = bus.cen & r_armed & ~w_wr_req & (r_cnt == '0);

  // Next request/active masks; using the post-write request makes an ACK beat a fire.
  always_comb begin
    w_req_d = r_req;
    if (w_wr_req) begin
      w_req_d = bus.din[CHN-1:0];
    end else if (w_wr_ack) begin
      w_req_d = r_req & ~bus.din[CHN-1:0];
    end
    w_act_d = w_req_d & (r_act | {CHN{w_fire}});
  end

  // Free-running Galois LFSR, advances every clk regardless of cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Bus registers, shared delay counter and interrupt outputs, all gated by cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= '0;
      r_act   <= '0;
      r_irq_n <= '1;
      r_dly   <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else if (bus.cen) begin
      r_req   <= w_req_d;
      r_act   <= w_act_d;
      r_irq_n <= ~r_act;
      if (w_wr_dly) begin
        r_dly  <= bus.din[DLYW-1:0];
        r_mode <= bus.din[7];
      end
      if (w_wr_req) begin
        r_cnt   <= r_mode ? r_lfsr[DLYW-1:0] : r_dly;
        r_armed <= 1'b1;
      end else if (r_armed) begin
        // Disarm at zero so the counter never wraps.
        if (r_cnt == '0) begin
          r_armed <= 1'b0;
        end else begin
          r_cnt <= r_cnt - DLYW'(1);
        end
      end
    end
  end

  // Finish countdown runs on every clk; done is sticky and freezes good.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good    <= 1'b0;
      r_done    <= 1'b0;
      r_fin_run <= 1'b0;
      r_fin_cnt <= '0;
    end else begin
      if (w_wr_ctrl && !r_done) begin
        r_good <= bus.din[1];
      end
      if (w_wr_ctrl && !r_done && bus.din[0]) begin
        r_fin_cnt <= FW'(FINISH_DLY);
        r_fin_run <= 1'b1;
      end else if (r_fin_run) begin
        if (r_fin_cnt == '0) begin
          r_done    <= 1'b1;
          r_fin_run <= 1'b0;
        end else begin
          r_fin_cnt <= r_fin_cnt - FW'(1);
        end
      end
    end
  end

  // Side-effect-free read mux; DELAY mode bit sits in bit 7.
  always_comb begin
    w_rd = '0;
    unique case (bus.addr)
      2'd0: w_rd = {5'b0, r_fin_run, r_done, r_good};
      2'd1: w_rd[CHN-1:0] = r_req;
      2'd2: begin
        w_rd[DLYW-1:0] = r_dly;
        w_rd[7]        = r_mode;
      end
      2'd3: w_rd[CHN-1:0] = r_act;
      default: w_rd = '0;
    endcase
  end

  assign bus.dout  = bus.cs ? w_rd : 8'h00;
  assign bus.irq_n = r_irq_n;
  assign bus.done  = r_done;
  assign bus.pass  = r_done & r_good;
  assign bus.fail  = r_done & ~r_good;

endmodule
